// File: rtl/ble_seq_pkg.sv
// Shared types for the BLE frame sequencer: FSM states, frame modes and the queued descriptor.
package ble_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HEADER,
    PAYLOAD,
    DRAIN,
    DONE
  } seq_state_e;

  localparam logic MODE_TX = 1'b0;
  localparam logic MODE_RX = 1'b1;

  // Field width of a stored descriptor; the sequencer's SIZE_W must not exceed it.
  localparam int DESC_SIZE_W = 16;

  typedef struct packed {
    logic                   mode;
    logic [DESC_SIZE_W-1:0] header_size;
    logic [DESC_SIZE_W-1:0] payload_size;
  } desc_t;

endpackage

// File: rtl/ble_frame_sequencer_if.sv
// Descriptor, chain, DMA and interrupt signals of the frame sequencer.
// master = software/DMA/chain side, slave = the sequencer itself.
interface ble_frame_sequencer_if #(
  parameter int SIZE_W     = 16,
  parameter int DESC_DEPTH = 4
);
  logic                          desc_valid;
  logic                          desc_ready;
  logic                          desc_mode;
  logic [SIZE_W-1:0]             desc_header_size;
  logic [SIZE_W-1:0]             desc_payload_size;
  logic [$clog2(DESC_DEPTH):0]   desc_count;
  logic                          chain_start;
  logic                          chain_mode;
  logic [SIZE_W-1:0]             chain_header_size;
  logic [SIZE_W-1:0]             chain_payload_size;
  logic                          sample_valid;
  logic                          abort;
  logic                          dma_req;
  logic                          dma_ack;
  logic [1:0]                    irq_en;
  logic [1:0]                    irq_clear;
  logic                          tx_irq;
  logic                          rx_irq;
  logic                          err_flag;
  logic                          busy;

  modport master (
    output desc_valid, desc_mode, desc_header_size, desc_payload_size,
           sample_valid, abort, dma_ack, irq_en, irq_clear,
    input  desc_ready, desc_count, chain_start, chain_mode, chain_header_size,
           chain_payload_size, dma_req, tx_irq, rx_irq, err_flag, busy
  );

  modport slave (
    input  desc_valid, desc_mode, desc_header_size, desc_payload_size,
           sample_valid, abort, dma_ack, irq_en, irq_clear,
    output desc_ready, desc_count, chain_start, chain_mode, chain_header_size,
           chain_payload_size, dma_req, tx_irq, rx_irq, err_flag, busy
  );
endinterface

// File: rtl/ble_desc_fifo.sv
// Generic synchronous FIFO with occupancy; head visible combinationally, 1-cycle write latency.
// Pushes are refused while full regardless of a same-cycle pop; pops on empty are ignored.
module ble_desc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/ble_frame_sequencer.sv
// Queues frame descriptors, launches each on the PHY chain, counts samples and issues burst DMA requests.
// Push-to-chain_start is 2 cycles; desc_ready tracks FIFO not-full only; DRAIN stalls until all bursts are acked.
import ble_seq_pkg::*;

module ble_frame_sequencer #(
  parameter int SIZE_W     = 16,
  parameter int DESC_DEPTH = 4,
  parameter int DMA_BURST  = 8,
  parameter int OUT_W      = 4
) (
  input  logic                  hclk,
  input  logic                  reset,
  ble_frame_sequencer_if.slave  bus
);
  localparam int CNT_W = $clog2(DESC_DEPTH) + 1;
  localparam logic [SIZE_W-1:0] BURST_MASK = SIZE_W'(DMA_BURST - 1);

  seq_state_e        state_q, state_d;
  logic [SIZE_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              mode_q, mode_d;
  logic [SIZE_W-1:0] hdr_q, hdr_d;
  logic [SIZE_W-1:0] pay_q, pay_d;
  logic              tx_status_q, tx_status_d;
  logic              rx_status_q, rx_status_d;
  logic              err_q, err_d;

  desc_t             push_desc, head_desc;
  logic              fifo_full, pop;
  logic [CNT_W-1:0]  fifo_count;
  logic              burst_inc, abort_hit, ack_ok, sat_err, done_hit;

  assign push_desc = '{mode:         bus.desc_mode,
                       header_size:  DESC_SIZE_W'(bus.desc_header_size),
                       payload_size: DESC_SIZE_W'(bus.desc_payload_size)};

  ble_desc_fifo #(
    .DEPTH (DESC_DEPTH),
    .W     ($bits(desc_t))
  ) u_fifo (
    .clk_i   (hclk),
    .rst_ni  (reset),
    .push_i  (bus.desc_valid),
    .pop_i   (pop),
    .data_i  (push_desc),
    .data_o  (head_desc),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign abort_hit = bus.abort && (state_q != IDLE);
  assign cnt_inc   = cnt_q + SIZE_W'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    hdr_d     = hdr_q;
    pay_d     = pay_q;
    pop       = 1'b0;
    burst_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_count != '0) begin
          pop     = 1'b1;
          mode_d  = head_desc.mode;
          hdr_d   = SIZE_W'(head_desc.header_size);
          pay_d   = SIZE_W'(head_desc.payload_size);
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (hdr_q != '0)      state_d = HEADER;
        else if (pay_q != '0) state_d = PAYLOAD;
        else                  state_d = DONE;
      end
      HEADER: begin
        if (bus.sample_valid) begin
          if (cnt_inc == hdr_q) begin
            cnt_d   = '0;
            state_d = (pay_q != '0) ? PAYLOAD : DRAIN;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      PAYLOAD: begin
        if (bus.sample_valid) begin
          // The final sample always closes a burst: full if aligned, partial otherwise.
          burst_inc = ((cnt_inc & BURST_MASK) == '0) || (cnt_inc == pay_q);
          if (cnt_inc == pay_q) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      DRAIN: if (out_q == '0) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_hit) begin
      state_d   = IDLE;
      cnt_d     = '0;
      burst_inc = 1'b0;
    end
  end

  always_comb begin
    ack_ok  = bus.dma_ack && (out_q != '0);
    out_d   = out_q;
    sat_err = 1'b0;
    if (abort_hit) begin
      out_d = '0;
    end else if (burst_inc && !ack_ok) begin
      if (out_q == '1) sat_err = 1'b1;
      else             out_d   = out_q + OUT_W'(1);
    end else if (!burst_inc && ack_ok) begin
      out_d = out_q - OUT_W'(1);
    end
  end

  // Setting a status bit takes priority over a same-cycle clear.
  assign done_hit    = (state_q == DONE) && !abort_hit;
  assign tx_status_d = (done_hit && mode_q == MODE_TX) || (tx_status_q && !bus.irq_clear[0]);
  assign rx_status_d = (done_hit && mode_q == MODE_RX) || (rx_status_q && !bus.irq_clear[1]);
  assign err_d       = abort_hit || sat_err || (err_q && !(&bus.irq_clear));

  always_ff @(posedge hclk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      out_q       <= '0;
      mode_q      <= 1'b0;
      hdr_q       <= '0;
      pay_q       <= '0;
      tx_status_q <= 1'b0;
      rx_status_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      mode_q      <= mode_d;
      hdr_q       <= hdr_d;
      pay_q       <= pay_d;
      tx_status_q <= tx_status_d;
      rx_status_q <= rx_status_d;
      err_q       <= err_d;
    end
  end

  assign bus.desc_ready         = !fifo_full;
  assign bus.desc_count         = fifo_count;
  assign bus.chain_start        = (state_q == LOAD);
  assign bus.chain_mode         = mode_q;
  assign bus.chain_header_size  = hdr_q;
  assign bus.chain_payload_size = pay_q;
  assign bus.dma_req            = (out_q != '0);
  assign bus.tx_irq             = tx_status_q && bus.irq_en[0];
  assign bus.rx_irq             = rx_status_q && bus.irq_en[1];
  assign bus.err_flag           = err_q;
  assign bus.busy               = (state_q != IDLE);
endmodule

// File: tb/tb_ble_frame_sequencer.sv
// Directed bench for ble_frame_sequencer: frame table plus hand-written FIFO, abort, held-ack and clear sequences.
module tb_ble_frame_sequencer;
  import ble_seq_pkg::*;

  localparam int SIZE_W     = 16;
  localparam int DESC_DEPTH = 4;
  localparam int DMA_BURST  = 8;
  localparam int OUT_W      = 4;

  logic hclk = 1'b0;
  logic reset;

  ble_frame_sequencer_if #(.SIZE_W(SIZE_W), .DESC_DEPTH(DESC_DEPTH)) bus ();

  ble_frame_sequencer #(
    .SIZE_W(SIZE_W), .DESC_DEPTH(DESC_DEPTH), .DMA_BURST(DMA_BURST), .OUT_W(OUT_W)
  ) dut (
    .hclk  (hclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic       mode;
    int         hdr;
    int         pay;
    logic [1:0] en;
    int         acks;
    int         rises;
    logic       tx;
    logic       rx;
  } vec_t;

  vec_t vecs[6];
  int   fh[6] = '{1, 2, 3, 4, 5, 7};
  int   fp[6] = '{2, 3, 1, 1, 2, 7};
  int   fc[5] = '{1, 1, 2, 3, 4};
  int   n_chk, n_err, n_start, n_ack, n_rise;
  logic auto_ack, req_prev;
  int   starts_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: count acks delivered, step past the edge, then sample outputs.
  task automatic cyc();
    if (bus.dma_ack && bus.dma_req) n_ack++;
    @(posedge hclk);
    #1;
    if (bus.chain_start) begin
      n_start++;
      starts_q.push_back(int'(bus.chain_header_size));
    end
    if (bus.dma_req && !req_prev) n_rise++;
    req_prev    = bus.dma_req;
    bus.dma_ack = auto_ack && bus.dma_req;
  endtask

  task automatic push(input logic m, input int h, input int p);
    bus.desc_valid        = 1'b1;
    bus.desc_mode         = m;
    bus.desc_header_size  = SIZE_W'(h);
    bus.desc_payload_size = SIZE_W'(p);
    cyc();
    bus.desc_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    i = 0;
    while (bus.busy && i < budget) begin
      cyc();
      i++;
    end
    chk(name, bus.busy, 1'b0);
  endtask

  task automatic clear_all();
    bus.irq_clear = 2'b11;
    cyc();
    bus.irq_clear = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    seq_state_e es;
    n_chk = 0; n_err = 0; n_start = 0; n_ack = 0; n_rise = 0;
    auto_ack = 1'b0; req_prev = 1'b0;
    bus.desc_valid = 1'b0; bus.desc_mode = 1'b0;
    bus.desc_header_size = '0; bus.desc_payload_size = '0;
    bus.sample_valid = 1'b0; bus.abort = 1'b0; bus.dma_ack = 1'b0;
    bus.irq_en = 2'b00; bus.irq_clear = 2'b00;
    reset = 1'b0;

    vecs[0] = '{MODE_TX, 4, 16, 2'b01, 2, 2, 1'b1, 1'b0};
    vecs[1] = '{MODE_RX, 0, 13, 2'b11, 2, 2, 1'b0, 1'b1};
    vecs[2] = '{MODE_RX, 3,  8, 2'b10, 1, 1, 1'b0, 1'b1};
    vecs[3] = '{MODE_TX, 2,  1, 2'b00, 1, 1, 1'b0, 1'b0};
    vecs[4] = '{MODE_RX, 5,  0, 2'b11, 0, 0, 1'b0, 1'b1};
    vecs[5] = '{MODE_TX, 0, 17, 2'b01, 3, 2, 1'b1, 1'b0};

    repeat (3) @(posedge hclk);
    #1;
    chk("rst_desc_ready", bus.desc_ready, 1'b1);
    chk("rst_desc_count", bus.desc_count, '0);
    chk("rst_outputs", {bus.chain_start, bus.chain_mode, bus.dma_req, bus.tx_irq,
                        bus.rx_irq, bus.err_flag, bus.busy}, '0);
    chk("rst_chain_sizes", {bus.chain_header_size, bus.chain_payload_size}, '0);
    reset = 1'b1;
    cyc();

    // Table of complete frames with immediate acks.
    auto_ack = 1'b1;
    for (int v = 0; v < 6; v++) begin
      n_start = 0; n_ack = 0; n_rise = 0;
      bus.irq_en = vecs[v].en;
      push(vecs[v].mode, vecs[v].hdr, vecs[v].pay);
      cyc();
      chk($sformatf("v%0d_start_lat", v), bus.chain_start, 1'b1);
      chk($sformatf("v%0d_chain_mode", v), bus.chain_mode, vecs[v].mode);
      chk($sformatf("v%0d_chain_sizes", v), {bus.chain_header_size, bus.chain_payload_size},
          (vecs[v].hdr << 16) | vecs[v].pay);
      cyc();
      es = (vecs[v].hdr != 0) ? HEADER : ((vecs[v].pay != 0) ? PAYLOAD : DONE);
      chk($sformatf("v%0d_first_state", v), 32'(dut.state_q), 32'(es));
      bus.sample_valid = 1'b1;
      repeat (vecs[v].hdr + vecs[v].pay) cyc();
      bus.sample_valid = 1'b0;
      if (vecs[v].hdr + vecs[v].pay > 0) begin
        chk($sformatf("v%0d_drain", v), 32'(dut.state_q), 32'(DRAIN));
        chk($sformatf("v%0d_drain_req", v), bus.dma_req, (vecs[v].pay != 0));
      end
      wait_idle($sformatf("v%0d_idle_timeout", v), 20);
      chk($sformatf("v%0d_starts", v), n_start, 1);
      chk($sformatf("v%0d_acks", v), n_ack, vecs[v].acks);
      chk($sformatf("v%0d_req_rises", v), n_rise, vecs[v].rises);
      chk($sformatf("v%0d_tx_irq", v), bus.tx_irq, vecs[v].tx);
      chk($sformatf("v%0d_rx_irq", v), bus.rx_irq, vecs[v].rx);
      chk($sformatf("v%0d_err", v), bus.err_flag, 1'b0);
      clear_all();
    end

    // Held acks: 32-sample payload builds 4 outstanding bursts.
    auto_ack = 1'b0;
    bus.irq_en = 2'b01;
    push(MODE_TX, 0, 32);
    cyc();
    cyc();
    bus.sample_valid = 1'b1;
    repeat (32) cyc();
    bus.sample_valid = 1'b0;
    chk("held_out4", dut.out_q, 4);
    repeat (3) cyc();
    chk("held_drain_wait", 32'(dut.state_q), 32'(DRAIN));
    chk("held_req", bus.dma_req, 1'b1);
    for (int k = 0; k < 4; k++) begin
      bus.dma_ack = 1'b1;
      cyc();
      chk($sformatf("held_out_after_ack%0d", k), dut.out_q, 3 - k);
      chk($sformatf("held_state_ack%0d", k), 32'(dut.state_q), 32'(DRAIN));
    end
    chk("held_req_drop", bus.dma_req, 1'b0);
    cyc();
    chk("held_done", 32'(dut.state_q), 32'(DONE));
    cyc();
    chk("held_tx_irq", bus.tx_irq, 1'b1);
    clear_all();

    // FIFO full: first frame stalls in HEADER while the queue fills.
    auto_ack = 1'b1;
    bus.irq_en = 2'b00;
    starts_q.delete();
    for (int i = 0; i < 5; i++) begin
      push(i[0], fh[i], fp[i]);
      chk($sformatf("fifo_count%0d", i), bus.desc_count, fc[i]);
    end
    chk("fifo_full_ready", bus.desc_ready, 1'b0);
    push(MODE_RX, fh[5], fp[5]);
    chk("fifo_reject_count", bus.desc_count, 4);
    chk("fifo_reject_ready", bus.desc_ready, 1'b0);
    bus.sample_valid = 1'b1;
    for (int i = 0; i < 300 && (bus.busy || bus.desc_count != 0); i++) cyc();
    bus.sample_valid = 1'b0;
    chk("fifo_drain_timeout", {bus.busy, bus.desc_count}, '0);
    chk("fifo_launches", starts_q.size(), 5);
    for (int i = 0; i < 5 && i < starts_q.size(); i++)
      chk($sformatf("fifo_order%0d", i), starts_q[i], fh[i]);
    clear_all();

    // Abort at payload sample 5 with a second frame queued behind it.
    bus.irq_en = 2'b11;
    n_start = 0;
    push(MODE_TX, 2, 16);
    push(MODE_RX, 1, 3);
    cyc();
    bus.sample_valid = 1'b1;
    repeat (6) cyc();
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    bus.sample_valid = 1'b0;
    chk("abort_idle", bus.busy, 1'b0);
    chk("abort_req", bus.dma_req, 1'b0);
    chk("abort_err", bus.err_flag, 1'b1);
    chk("abort_no_irq", {bus.tx_irq, bus.rx_irq}, 2'b00);
    chk("abort_fifo_kept", bus.desc_count, 1);
    cyc();
    chk("abort_next_start", {bus.chain_start, bus.chain_mode}, 2'b11);
    cyc();
    bus.sample_valid = 1'b1;
    repeat (4) cyc();
    bus.sample_valid = 1'b0;
    wait_idle("abort_next_timeout", 20);
    chk("abort_next_irq", {bus.tx_irq, bus.rx_irq}, 2'b01);
    chk("abort_err_sticky", bus.err_flag, 1'b1);
    bus.irq_clear = 2'b01;
    cyc();
    bus.irq_clear = 2'b00;
    chk("err_half_clear", bus.err_flag, 1'b1);
    chk("rx_kept_on_tx_clear", bus.rx_irq, 1'b1);
    clear_all();
    chk("err_full_clear", {bus.err_flag, bus.rx_irq}, 2'b00);

    // Zero-size frame with a clear colliding with the status set.
    bus.irq_en = 2'b00;
    push(MODE_TX, 0, 0);
    cyc();
    chk("zero_start", bus.chain_start, 1'b1);
    cyc();
    chk("zero_done", 32'(dut.state_q), 32'(DONE));
    bus.irq_clear = 2'b01;
    cyc();
    bus.irq_clear = 2'b00;
    chk("zero_status_wins", dut.tx_status_q, 1'b1);
    chk("zero_irq_masked", bus.tx_irq, 1'b0);
    bus.irq_en = 2'b01;
    #1;
    chk("zero_irq_enabled", bus.tx_irq, 1'b1);
    bus.irq_clear = 2'b01;
    cyc();
    bus.irq_clear = 2'b00;
    chk("zero_irq_cleared", bus.tx_irq, 1'b0);

    // Reset mid-frame discards the running frame and the queue.
    push(MODE_RX, 9, 9);
    push(MODE_TX, 1, 1);
    cyc();
    bus.sample_valid = 1'b1;
    repeat (3) cyc();
    bus.sample_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("mrst_busy", bus.busy, 1'b0);
    chk("mrst_fifo", {bus.desc_ready, bus.desc_count}, {1'b1, 3'd0});
    chk("mrst_chain", {bus.chain_start, bus.chain_header_size}, '0);
    @(posedge hclk);
    #1;
    reset = 1'b1;
    repeat (3) cyc();
    chk("mrst_stays_idle", {bus.busy, bus.chain_start}, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
